// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered 2^ADDR_W x 2^ADDR_W pixel store between the tracer and the VGA stage.
// Buffers swap only on a vsync falling edge after frame_done, optionally clearing the new back bank.
module frame_buffer #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 12,
   parameter logic [DATA_W-1:0] BG_COLOR = 12'h000,
   parameter bit CLEAR_ON_SWAP = 1'b1
) (
   input  logic              vga_clk,
   input  logic              clr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_x,
   input  logic [ADDR_W-1:0] wr_y,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              frame_done,
   output logic              swap_pending,
   output logic              clearing,
   output logic              front_sel,
   input  logic              vs,
   input  logic [ADDR_W-1:0] col_addr,
   input  logic [ADDR_W-1:0] row_addr,
   output logic [DATA_W-1:0] din
);
   localparam int AW = 2 * ADDR_W;
   localparam int DEPTH = 1 << AW;
   typedef enum logic [1:0] {CLR_ALL, WRITE, WAIT_SWAP, CLR_BACK} state_t;
   state_t state;
   logic [AW-1:0] clr_cnt, waddr, raddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] bank0 [DEPTH];
   logic [DATA_W-1:0] bank1 [DEPTH];
   logic vs_q, sweep, back_we, we0, we1, last, swap;
   always_comb begin
      sweep = (state == CLR_ALL) || (state == CLR_BACK);
      last = &clr_cnt;
      swap = (state == WAIT_SWAP) && vs_q && !vs;
      waddr = sweep ? clr_cnt : {wr_y, wr_x};
      wdata = sweep ? BG_COLOR : wr_data;
      raddr = {row_addr, col_addr};
      back_we = (wr_valid && wr_ready) || (state == CLR_BACK);
      we0 = (state == CLR_ALL) || (back_we && front_sel);
      we1 = (state == CLR_ALL) || (back_we && !front_sel);
   end
   // storage is left unreset so it maps onto block RAM
   always_ff @(posedge vga_clk) begin
      if (we0) bank0[waddr] <= wdata;
      if (we1) bank1[waddr] <= wdata;
   end
   always_ff @(posedge vga_clk) begin
      if (clr) din <= '0;
      else din <= front_sel ? bank1[raddr] : bank0[raddr];
   end
   always_ff @(posedge vga_clk) begin
      if (clr) begin
         state <= CLR_ALL;
         front_sel <= 1'b0;
         swap_pending <= 1'b0;
         wr_ready <= 1'b0;
         clearing <= 1'b1;
         clr_cnt <= '0;
         vs_q <= 1'b1;
      end else begin
         vs_q <= vs;
         if (sweep) clr_cnt <= clr_cnt + AW'(1);
         case (state)
            CLR_ALL, CLR_BACK: if (last) begin
               state <= WRITE;
               clearing <= 1'b0;
               wr_ready <= 1'b1;
            end
            WRITE: if (frame_done) begin
               state <= WAIT_SWAP;
               swap_pending <= 1'b1;
               wr_ready <= 1'b0;
            end
            default: if (swap) begin
               front_sel <= !front_sel;
               swap_pending <= 1'b0;
               state <= CLEAR_ON_SWAP ? CLR_BACK : WRITE;
               clearing <= CLEAR_ON_SWAP;
               wr_ready <= !CLEAR_ON_SWAP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: directed checks of clear sweeps, write/swap handshake, vsync gating and reset.
module tb_frame_buffer;
   logic vga_clk = 1'b0, clr = 1'b0, wr_valid = 1'b0, frame_done = 1'b0, vs = 1'b1;
   logic [6:0] wr_x = '0, wr_y = '0, col_addr = '0, row_addr = '0;
   logic [11:0] wr_data = '0;
   logic wr_ready, swap_pending, clearing, front_sel;
   logic [11:0] din;
   int errors = 0, checks = 0;
   frame_buffer dut (
      .vga_clk(vga_clk), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .frame_done(frame_done),
      .swap_pending(swap_pending), .clearing(clearing), .front_sel(front_sel),
      .vs(vs), .col_addr(col_addr), .row_addr(row_addr), .din(din)
   );
   always #5 vga_clk = ~vga_clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask
   task automatic rd(input string tag, input logic [6:0] r, input logic [6:0] c, input logic [11:0] exp);
      row_addr = r;
      col_addr = c;
      tick();
      chk(tag, 32'(din), 32'(exp));
   endtask
   task automatic wr(input logic [6:0] x, input logic [6:0] y, input logic [11:0] d, input logic fd);
      wr_valid = 1'b1;
      wr_x = x;
      wr_y = y;
      wr_data = d;
      frame_done = fd;
      tick();
      wr_valid = 1'b0;
      frame_done = 1'b0;
   endtask
   task automatic pulse_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask
   task automatic do_swap(input logic exp_front);
      vs = 1'b0;
      tick();
      vs = 1'b1;
      chk("swap_front", 32'(front_sel), 32'(exp_front));
      chk("swap_pending_clr", 32'(swap_pending), 0);
      chk("swap_clearing", 32'(clearing), 1);
      chk("swap_ready", 32'(wr_ready), 0);
   endtask
   task automatic wait_clear(input string tag, input int exp);
      int n = 0;
      while (clearing && n < 20000) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'(exp));
      chk("ready_after_clear", 32'(wr_ready), 1);
   endtask
   task automatic reset_check();
      chk("rst_front", 32'(front_sel), 0);
      chk("rst_din", 32'(din), 0);
      chk("rst_pending", 32'(swap_pending), 0);
      chk("rst_ready", 32'(wr_ready), 0);
      chk("rst_clearing", 32'(clearing), 1);
   endtask
   initial begin
      int hi;
      clr = 1'b1;
      tick();
      tick();
      reset_check();
      clr = 1'b0;
      wait_clear("clr_all_len", 16384);
      rd("rd_0_0", 0, 0, 12'h000);
      rd("rd_127_127", 127, 127, 12'h000);
      rd("rd_64_3", 64, 3, 12'h000);
      vs = 1'b0;
      tick();
      vs = 1'b1;
      tick();
      chk("vs_in_write_ignored", 32'(front_sel), 0);
      wr(5, 9, 12'hABC, 1'b0);
      wr(3, 3, 12'h123, 1'b1);
      chk("pending_set", 32'(swap_pending), 1);
      chk("ready_drop", 32'(wr_ready), 0);
      rd("front_not_written", 9, 5, 12'h000);
      wr_valid = 1'b1;
      wr_x = 5;
      wr_y = 9;
      wr_data = 12'hFFF;
      hi = 0;
      for (int i = 0; i < 500; i++) begin
         frame_done = (i % 100) == 7;
         tick();
         if (wr_ready) hi++;
      end
      frame_done = 1'b0;
      chk("hold_ready_low", 32'(hi), 0);
      chk("hold_no_swap", 32'(front_sel), 0);
      chk("hold_pending", 32'(swap_pending), 1);
      do_swap(1'b1);
      wr_valid = 1'b0;
      rd("front_abc", 9, 5, 12'hABC);
      rd("front_123", 3, 3, 12'h123);
      vs = 1'b0;
      frame_done = 1'b1;
      tick();
      vs = 1'b1;
      frame_done = 1'b0;
      chk("no_double_swap", 32'(front_sel), 1);
      chk("no_pending_in_clr", 32'(swap_pending), 0);
      wait_clear("clr_back1_len", 16384 - 3);
      rd("front_abc_after", 9, 5, 12'hABC);
      wr(1, 2, 12'h456, 1'b0);
      pulse_done();
      tick();
      do_swap(1'b0);
      rd("front2_456", 2, 1, 12'h456);
      rd("front2_bg", 9, 5, 12'h000);
      wait_clear("clr_back2_len", 16384 - 2);
      pulse_done();
      tick();
      do_swap(1'b1);
      rd("cleared_abc", 9, 5, 12'h000);
      rd("cleared_123", 3, 3, 12'h000);
      for (int i = 0; i < 7998; i++) tick();
      chk("mid_sweep_clearing", 32'(clearing), 1);
      clr = 1'b1;
      tick();
      reset_check();
      clr = 1'b0;
      wait_clear("clr_all_restart_len", 16384);
      chk("final_front", 32'(front_sel), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered 128x128 pixel store, 12-bit colour per pixel, sitting directly upstream of the VGA timing stage.
- The tracer writes pixels into the back buffer through a valid/ready port.
- The VGA stage reads the front buffer using its registered col_addr/row_addr and receives din one cycle later.
- Buffers swap only during vertical sync, so the display never shows a half-written frame.

Parameters:
- ADDR_W, 7, bits per coordinate; each buffer holds 2^(2*ADDR_W) pixels.
- DATA_W, 12, pixel width: {b[3:0], g[3:0], r[3:0]} in bits [11:8], [7:4], [3:0].
- BG_COLOR, 12'h000, value written by clear operations.
- CLEAR_ON_SWAP, 1, 1 = clear the new back buffer after each swap; 0 = leave stale contents.

Ports:
- vga_clk  in  1  sole clock; all logic on its rising edge.
- clr  in  1  reset, synchronous, active-high.
- wr_valid  in  1  tracer presents a pixel write.
- wr_ready  out  1  block accepts the write this cycle.
- wr_x  in  ADDR_W  column of the pixel write.
- wr_y  in  ADDR_W  row of the pixel write.
- wr_data  in  DATA_W  pixel colour to write.
- frame_done  in  1  one-cycle pulse: tracer has finished the back frame.
- swap_pending  out  1  frame_done accepted, waiting for vsync.
- clearing  out  1  clear sweep in progress.
- front_sel  out  1  index of the buffer currently displayed.
- vs  in  1  vertical sync from the VGA stage; low during the 2 sync lines.
- col_addr  in  ADDR_W  VGA read column.
- row_addr  in  ADDR_W  VGA read row.
- din  out  DATA_W  front-buffer pixel at {row_addr, col_addr}, registered.

Behaviour:
- Storage: two banks of 2^(2*ADDR_W) x DATA_W. Index = {row, col}, row in the MSBs. Back bank = ~front_sel.
- Read path, registered, 1-cycle latency:
  - din <= bank[front_sel][{row_addr, col_addr}].
  - The read always uses the front_sel value from before the edge.
  - A swap takes effect on the read issued in the cycle after the toggle.
- Reset (clr=1 at an edge): front_sel=0, din=0, swap_pending=0, wr_ready=0, clearing=1, clear counter=0, vs_q=1, state=CLR_ALL. Reset mid-operation abandons any sweep or pending swap; contents already written are not restored.
- State machine:
  - CLR_ALL:
    - Writes BG_COLOR to one address per cycle in both banks, counter 0..2^(2*ADDR_W)-1.
    - After the last address: state=WRITE, clearing=0.
    - Duration: 16384 cycles at default.
  - WRITE:
    - wr_ready=1.
    - A handshake (wr_valid & wr_ready) writes wr_data to bank[~front_sel][{wr_y, wr_x}] on that edge.
    - frame_done=1 -> WAIT_SWAP, swap_pending=1. A handshake in the same cycle as frame_done is still written.
  - WAIT_SWAP:
    - wr_ready=0; writes are refused and the tracer holds.
    - Swap condition: vs_q=1 & vs=0 (falling edge, vs_q = vs registered).
    - On the swap condition: front_sel toggles, swap_pending=0. Then, if CLEAR_ON_SWAP=1, state=CLR_BACK and clearing=1; otherwise state=WRITE.
  - CLR_BACK:
    - Clears bank[~front_sel] (the new back bank) only, 2^(2*ADDR_W) cycles, then state=WRITE.
    - Front-bank reads continue undisturbed.
- frame_done is ignored outside WRITE. vs edges are ignored outside WAIT_SWAP; a swap never happens without a preceding accepted frame_done.
- Clear counter is 2*ADDR_W bits wide and returns to 0 after the terminal count.
- wr_ready is a registered decode of state and depends only on state, never combinationally on wr_valid.
- Read and write ports are independent: same-cycle write to the back bank and read of the front bank never conflict. Front bank is never written outside clear sweeps.

Test Plan:
- Reset clears: assert clr 1 cycle, wait 16384 cycles -> clearing falls, wr_ready=1. Reading addresses {0,0}, {127,127}, {64,3} -> din=12'h000 one cycle after each address.
- Write then swap: write 12'hABC to (x=5, y=9), pulse frame_done -> swap_pending=1, wr_ready=0. Drive vs 1->0 -> front_sel=1, swap_pending=0. Read row 9, col 5 -> din=12'hABC one cycle later.
- Same-cycle write and frame_done: wr_valid with (3, 3, 12'h123) and frame_done in one cycle -> pixel stored, WAIT_SWAP entered. After swap, read (3, 3) -> 12'h123.
- Hold during wait: in WAIT_SWAP, hold wr_valid=1 for 500 cycles with vs=1 -> wr_ready stays 0, nothing written. Extra frame_done pulses cause no double swap.
- CLEAR_ON_SWAP=1: after swap, clearing=1 for 16384 cycles while front reads still return the displayed frame. The back bank then reads BG_COLOR after the next swap for all unwritten pixels.
- Reset mid-sweep: assert clr at cycle 8000 of CLR_BACK -> front_sel=0, din=0, CLR_ALL restarts from address 0.
